alu_cmd_sequencer: RTL
======================

# alu_cmd_sequencer

Upstream feeder for the 8-bit `alu`. It buffers operation commands (A, B, ALU_Sel) in a small FIFO and issues them to the ALU one at a time. It waits a fixed ALU latency, captures ALU_Out/CarryOut and returns each result on a valid/ready response port. It replaces bench-driven operand sequencing, so the ALU can be driven from any handshaking source in the physical-synthesis flow.

## Interface
- `DEPTH`, 4: command FIFO entries; power of 2, ≥2.
- `ALU_LAT`, 1: register stages inside the ALU between operands and ALU_Out; ≥1.
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  FIFO can accept (not full, not in reset).
- `cmd_a`  in  8  operand A.
- `cmd_b`  in  8  operand B.
- `cmd_sel`  in  4  ALU opcode.
- `A`  out  8  registered operand to ALU.
- `B`  out  8  registered operand to ALU.
- `ALU_Sel`  out  4  registered opcode to ALU.
- `ALU_Out`  in  8  ALU result.
- `CarryOut`  in  1  ALU carry.
- `rsp_valid`  out  1  response held.
- `rsp_ready`  in  1  consumer accepts.
- `rsp_out`  out  8  captured ALU_Out.
- `rsp_carry`  out  1  captured CarryOut.
- `rsp_sel`  out  4  opcode that produced the response.
- `busy`  out  1  FSM not IDLE or FIFO non-empty.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- FIFO: push on `cmd_valid && cmd_ready`; `cmd_ready = !full`; a push while full is ignored; push and pop in the same cycle are allowed when not full; pointers wrap modulo DEPTH.
- FSM states: IDLE, WAIT, RESP.
- IDLE: if FIFO is non-empty, pop head, load A/B/ALU_Sel, load wait counter with ALU_LAT, go to WAIT.
- WAIT: decrement the counter each cycle. On the cycle the counter is 0, capture ALU_Out/CarryOut and the issued ALU_Sel into rsp regs, set rsp_valid and go to RESP.
- RESP: hold the rsp regs stable while `rsp_valid && !rsp_ready`.
- On handshake, clear rsp_valid. If the FIFO is non-empty, pop and issue in the same edge and go to WAIT; otherwise go to IDLE.
- A/B/ALU_Sel keep the last issued values while idle.
- ALU_Sel 4'h3 is passed through unchanged; the sequencer does not interpret opcodes.
- Reset (async, any state): FIFO flushed, in-flight op discarded with no response, FSM to IDLE.
- Reset values: A=0, B=0, ALU_Sel=0, rsp_valid=0, rsp_out=0, rsp_carry=0, rsp_sel=0, count=0, busy=0; cmd_ready=0 while reset is low, 1 after release.

## Timing
- A command accepted at edge N into an empty, idle sequencer issues at edge N+1: A/B/ALU_Sel are valid after N+1.
- Capture occurs at edge N+1+ALU_LAT+1; rsp_valid is high after that edge. For default ALU_LAT=1, that is 3 cycles from acceptance.
- Back-to-back with rsp_ready held high: one response every ALU_LAT+2 cycles.
- count updates on the edge after push/pop; push and pop in the same cycle leave count unchanged.
- No combinational path from cmd_* or ALU_Out to any output, except cmd_ready from reset.

## Configuration
- `ALU_SEQ_STATS_EN`
  - Defined: adds output `op_count` [15:0]. It increments on every response handshake, wraps 16'hFFFF→0, and resets to 0.
  - Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
The bench uses a stub ALU (ALU_LAT=1, registered: ALU_Out = A+B[7:0], CarryOut = carry).
- Single op: push a=8'h0F, b=8'h01, sel=4'h0 at edge 0, rsp_ready=1 → rsp_valid high after edge 3 with rsp_out=8'h10, rsp_carry=0, rsp_sel=0; busy=0 afterwards.
- Carry/wrap: a=8'hFF, b=8'h02 → rsp_out=8'h01, rsp_carry=1.
- Full FIFO with rsp_ready=0: push 6 commands → cmd_ready low once count=4, with one command held in RESP and 4 in the FIFO; the excess push is dropped. Releasing rsp_ready returns 5 responses in order, spaced 3 cycles apart.
- Response backpressure: hold rsp_ready=0 for 10 cycles → rsp_out/rsp_carry/rsp_sel stable and no new issue; A/B unchanged until the handshake.
- Reset mid-WAIT: assert reset one cycle after issue → all outputs at reset values immediately, count=0, no response after release; the next command behaves as in the single-op case.
- With `ALU_SEQ_STATS_EN`: 3 handshakes → op_count=3; reset → 0.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Command FIFO + issue/wait/respond sequencer feeding a registered 8-bit ALU.
// Optional `ALU_SEQ_STATS_EN adds a 16-bit response handshake counter (op_count).
module alu_cmd_sequencer #(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [7:0]             cmd_a,
    input  logic [7:0]             cmd_b,
    input  logic [3:0]             cmd_sel,
    output logic [7:0]             A,
    output logic [7:0]             B,
    output logic [3:0]             ALU_Sel,
    input  logic [7:0]             ALU_Out,
    input  logic                   CarryOut,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [7:0]             rsp_out,
    output logic                   rsp_carry,
    output logic [3:0]             rsp_sel,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] count
`ifdef ALU_SEQ_STATS_EN
    ,
    output logic [15:0]            op_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int LW = $clog2(ALU_LAT + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] sel;
    } cmd_t;

    cmd_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    state_t        state_q, state_d;
    logic [LW-1:0] wait_q, wait_d;
    logic [7:0]    a_q, a_d, b_q, b_d;
    logic [3:0]    sel_q, sel_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [7:0]    rsp_out_q, rsp_out_d;
    logic          rsp_carry_q, rsp_carry_d;
    logic [3:0]    rsp_sel_q, rsp_sel_d;

    logic full, empty, push, pop, handshake;
    cmd_t head;

`ifdef ALU_SEQ_STATS_EN
    logic [15:0] op_count_q, op_count_d;
`endif

    always_comb begin
        full  = (count_q == CW'(DEPTH));
        empty = (count_q == '0);
        push  = cmd_valid && !full;
        head  = mem_q[rd_ptr_q];
    end

    // Only output with a combinational input: held low throughout reset.
    assign cmd_ready = reset && !full;

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        a_d         = a_q;
        b_d         = b_q;
        sel_d       = sel_q;
        rsp_valid_d = rsp_valid_q;
        rsp_out_d   = rsp_out_q;
        rsp_carry_d = rsp_carry_q;
        rsp_sel_d   = rsp_sel_q;
        pop         = 1'b0;
        handshake   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                pop = !empty;
            end
            S_WAIT: begin
                if (wait_q == '0) begin
                    rsp_out_d   = ALU_Out;
                    rsp_carry_d = CarryOut;
                    rsp_sel_d   = sel_q;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    wait_d = wait_q - LW'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    handshake   = 1'b1;
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                    pop         = !empty;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Issue shares one path from IDLE and from a RESP handshake.
        if (pop) begin
            a_d     = head.a;
            b_d     = head.b;
            sel_d   = head.sel;
            wait_d  = LW'(ALU_LAT);
            state_d = S_WAIT;
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
`ifdef ALU_SEQ_STATS_EN
        op_count_d = handshake ? op_count_q + 16'd1 : op_count_q;
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            wait_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sel_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_out_q   <= '0;
            rsp_carry_q <= 1'b0;
            rsp_sel_q   <= '0;
`ifdef ALU_SEQ_STATS_EN
            op_count_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sel_q       <= sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_out_q   <= rsp_out_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_sel_q   <= rsp_sel_d;
`ifdef ALU_SEQ_STATS_EN
            op_count_q  <= op_count_d;
`endif
        end
    end

    // Storage needs no reset: entries are only read once the count says they are valid.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_a, cmd_b, cmd_sel};
        end
    end

    assign A         = a_q;
    assign B         = b_q;
    assign ALU_Sel   = sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_out   = rsp_out_q;
    assign rsp_carry = rsp_carry_q;
    assign rsp_sel   = rsp_sel_q;
    assign count     = count_q;
    assign busy      = (state_q != S_IDLE) || !empty;
`ifdef ALU_SEQ_STATS_EN
    assign op_count  = op_count_q;
`endif

endmodule
